// File: rtl/instr_sequencer_pkg.sv
// Shared types and constants for the multi-cycle instruction sequencer:
// FSM states, instruction classes, ARM condition codes and compare commands.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_SHIFT_RD = 3'd3,
    ST_EXEC     = 3'd4,
    ST_MUL      = 3'd5,
    ST_MEM      = 3'd6,
    ST_WB       = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CL_DP  = 2'd0,
    CL_MEM = 2'd1,
    CL_BR  = 2'd2,
    CL_MUL = 2'd3
  } iclass_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [3:0] CMD_TST = 4'd8;
  localparam logic [3:0] CMD_TEQ = 4'd9;
  localparam logic [3:0] CMD_CMP = 4'd10;
  localparam logic [3:0] CMD_CMN = 4'd11;

  // Compare-type DP commands only update flags; they never write a register.
  function automatic logic is_compare_cmd(input logic [3:0] cmd);
    return (cmd == CMD_TST) || (cmd == CMD_TEQ) || (cmd == CMD_CMP) || (cmd == CMD_CMN);
  endfunction

endpackage

// File: rtl/instr_sequencer_cond_check.sv
// ARM condition-code evaluation of IR[31:28] against NZCV flags.
module cond_check
  import seq_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n_f, z_f, c_f, v_f;
  assign {n_f, z_f, c_f, v_f} = flags;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_f;
      COND_NE: pass = ~z_f;
      COND_CS: pass = c_f;
      COND_CC: pass = ~c_f;
      COND_MI: pass = n_f;
      COND_PL: pass = ~n_f;
      COND_VS: pass = v_f;
      COND_VC: pass = ~v_f;
      COND_HI: pass = c_f & ~z_f;
      COND_LS: pass = ~c_f | z_f;
      COND_GE: pass = (n_f == v_f);
      COND_LT: pass = (n_f != v_f);
      COND_GT: pass = ~z_f & (n_f == v_f);
      COND_LE: pass = z_f | (n_f != v_f);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer gating the
// controller's write enables and issuing PC and IR strobes.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic [31:0] instr,
  input  logic        imem_valid,
  input  logic        dmem_ready,
  input  logic [3:0]  flags,
  output logic        imem_req,
  output logic        ir_en,
  output logic        rs_rd,
  output logic        alu_en,
  output logic        mul_step,
  output logic        dmem_req,
  output logic        dmem_wen,
  output logic        regfile_wen,
  output logic        update_flags,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        busy
);

  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] mul_cnt_reg, mul_cnt_next;
  logic [31:0]   ir_reg;

  iclass_t iclass;
  logic    cond_pass, s_bit, reg_shift, is_cmp, boundary_halt;
  logic    unused_ir_bits;

  assign iclass         = iclass_t'(ir_reg[27:26]);
  assign s_bit          = ir_reg[20];
  assign reg_shift      = ~ir_reg[25] & ir_reg[4];
  assign is_cmp         = is_compare_cmd(ir_reg[24:21]);
  assign boundary_halt  = halt;
  assign unused_ir_bits = ^{ir_reg[19:5], ir_reg[3:0]};

  cond_check u_cond_check (
    .cond  (ir_reg[31:28]),
    .flags (flags),
    .pass  (cond_pass)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      mul_cnt_reg <= '0;
      ir_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      mul_cnt_reg <= mul_cnt_next;
      if (ir_en) ir_reg <= instr;
    end
  end

  always_comb begin
    state_next   = state_reg;
    mul_cnt_next = mul_cnt_reg;
    imem_req     = 1'b0;
    ir_en        = 1'b0;
    rs_rd        = 1'b0;
    alu_en       = 1'b0;
    mul_step     = 1'b0;
    dmem_req     = 1'b0;
    dmem_wen     = 1'b0;
    regfile_wen  = 1'b0;
    update_flags = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_en    = imem_valid;
        if (imem_valid) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (!cond_pass) begin
          pc_inc     = 1'b1;
          state_next = boundary_halt ? ST_IDLE : ST_FETCH;
        end else if (iclass == CL_MUL) begin
          mul_cnt_next = '0;
          state_next   = ST_MUL;
        end else if (iclass == CL_DP && reg_shift) begin
          state_next = ST_SHIFT_RD;
        end else begin
          state_next = ST_EXEC;
        end
      end
      ST_SHIFT_RD: begin
        rs_rd      = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        alu_en = 1'b1;
        case (iclass)
          CL_MEM:  state_next = ST_MEM;
          CL_BR: begin
            pc_load    = 1'b1;
            state_next = boundary_halt ? ST_IDLE : ST_FETCH;
          end
          default: state_next = ST_WB;
        endcase
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_cnt_reg == MUL_LAST) state_next = ST_WB;
        else                         mul_cnt_next = mul_cnt_reg + CW'(1);
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_wen = ~s_bit;
        if (dmem_ready) begin
          if (s_bit) begin
            state_next = ST_WB;
          end else begin
            // Stores have no writeback; the ready cycle closes the instruction.
            pc_inc     = 1'b1;
            state_next = boundary_halt ? ST_IDLE : ST_FETCH;
          end
        end
      end
      ST_WB: begin
        pc_inc       = 1'b1;
        regfile_wen  = ~((iclass == CL_DP) & is_cmp);
        update_flags = ((iclass == CL_DP) | (iclass == CL_MUL)) & s_bit;
        state_next   = boundary_halt ? ST_IDLE : ST_FETCH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state_reg != ST_IDLE);

endmodule
